// File: rtl/snn_pkg.sv
// Shared SNN definitions: default array geometry, clog2 helper, half-float constants.
// Pure declarations; no timing or flow control.
package snn_pkg;

  localparam int NUM_NEURONS_DEF = 8;
  localparam int ADDR_WIDTH_DEF  = 3;
  localparam int TS_WIDTH_DEF    = 16;

  localparam logic [15:0] FP16_ZERO = 16'h0000;
  localparam logic [15:0] FP16_HALF = 16'h3800;
  localparam logic [15:0] FP16_ONE  = 16'h3c00;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping N-1 -> 0.
// Zero latency; no flow control, the caller decides whether the grant is taken.
module rr_arbiter
  import snn_pkg::*;
#(
  parameter int N  = NUM_NEURONS_DEF,
  parameter int AW = ADDR_WIDTH_DEF
) (
  input  logic [N-1:0]  req,
  input  logic [AW-1:0] ptr,
  output logic          grant_valid,
  output logic [AW-1:0] grant_idx
);

  always_comb begin
    int j;
    logic [AW-1:0] idx;
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      idx = AW'(j);
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/spike_aer_arbiter.sv
// Latches neuron spikes and serialises them round-robin onto one timestamped AER stream; 2-cycle fire-to-valid.
// Holds addr/timestamp while aer_ready is low; a re-fire of a still-pending neuron is dropped and flagged (SPIKE_ARB_STARVE_GUARD_EN adds age-forced grants).
module spike_aer_arbiter
  import snn_pkg::*;
#(
  parameter int NUM_NEURONS = NUM_NEURONS_DEF,
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int TS_WIDTH    = TS_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_NEURONS-1:0] fired,
  input  logic                   timestep_tick,
  output logic                   aer_valid,
  input  logic                   aer_ready,
  output logic [ADDR_WIDTH-1:0]  aer_addr,
  output logic [TS_WIDTH-1:0]    aer_timestep,
  output logic                   overflow,
  input  logic                   clear_overflow
);

  logic [NUM_NEURONS-1:0] pending_q, pending_d, granted;
  logic                   valid_q, valid_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [TS_WIDTH-1:0]    ts_q, ts_d;
  logic [TS_WIDTH-1:0]    cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;
  logic [ADDR_WIDTH-1:0]  ptr_q, ptr_d;

  logic                   slot_free;
  logic                   rr_vld, grant_vld;
  logic [ADDR_WIDTH-1:0]  rr_idx, grant_idx;

  assign slot_free = ~valid_q | aer_ready;

  rr_arbiter #(
    .N  (NUM_NEURONS),
    .AW (ADDR_WIDTH)
  ) u_rr (
    .req         (pending_q),
    .ptr         (ptr_q),
    .grant_valid (rr_vld),
    .grant_idx   (rr_idx)
  );

`ifdef SPIKE_ARB_STARVE_GUARD_EN
  localparam int AGE_W = clog2(2 * NUM_NEURONS + 2);
  localparam logic [AGE_W-1:0] AGE_LIMIT = AGE_W'(2 * NUM_NEURONS);
  localparam logic [AGE_W-1:0] AGE_MAX   = AGE_W'(2 * NUM_NEURONS + 1);

  logic [AGE_W-1:0]      age_q [NUM_NEURONS];
  logic [AGE_W-1:0]      age_d [NUM_NEURONS];
  logic                  aged_vld;
  logic [ADDR_WIDTH-1:0] aged_idx;

  // Descending scan so the lowest aged index is the one left standing.
  always_comb begin
    aged_vld = 1'b0;
    aged_idx = '0;
    for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
      if (pending_q[i] && (age_q[i] > AGE_LIMIT)) begin
        aged_vld = 1'b1;
        aged_idx = ADDR_WIDTH'(i);
      end
    end
  end

  assign grant_vld = slot_free & rr_vld;
  assign grant_idx = aged_vld ? aged_idx : rr_idx;

  always_comb begin
    for (int i = 0; i < NUM_NEURONS; i++) begin
      if (!pending_d[i] || granted[i]) age_d[i] = '0;
      else if (age_q[i] != AGE_MAX)    age_d[i] = age_q[i] + AGE_W'(1);
      else                             age_d[i] = age_q[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_NEURONS; i++) age_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_NEURONS; i++) age_q[i] <= age_d[i];
    end
  end
`else
  assign grant_vld = slot_free & rr_vld;
  assign grant_idx = rr_idx;
`endif

  always_comb begin
    granted = '0;
    if (grant_vld) granted[grant_idx] = 1'b1;

    pending_d = (pending_q & ~granted) | fired;

    ovf_d = ovf_q;
    if (clear_overflow) ovf_d = 1'b0;
    // A fire on the granted index re-arms pending and is not a drop.
    if (|(fired & pending_q & ~granted)) ovf_d = 1'b1;

    cnt_d = cnt_q + TS_WIDTH'(timestep_tick);

    valid_d = valid_q;
    addr_d  = addr_q;
    ts_d    = ts_q;
    ptr_d   = ptr_q;
    if (grant_vld) begin
      valid_d = 1'b1;
      addr_d  = grant_idx;
      ts_d    = cnt_q;
      ptr_d   = (grant_idx == ADDR_WIDTH'(NUM_NEURONS - 1)) ? '0 : grant_idx + ADDR_WIDTH'(1);
    end else if (slot_free) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q <= '0;
      valid_q   <= 1'b0;
      addr_q    <= '0;
      ts_q      <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      ptr_q     <= '0;
    end else begin
      pending_q <= pending_d;
      valid_q   <= valid_d;
      addr_q    <= addr_d;
      ts_q      <= ts_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      ptr_q     <= ptr_d;
    end
  end

  assign aer_valid    = valid_q;
  assign aer_addr     = addr_q;
  assign aer_timestep = ts_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_spike_aer_arbiter.sv
// Directed bench for spike_aer_arbiter: scoreboard of accepted AER events plus cycle-exact checks.
module tb_spike_aer_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  fired;
  logic        tick;
  logic        aer_ready;
  logic        clr;
  logic        aer_valid;
  logic [2:0]  aer_addr;
  logic [15:0] aer_ts;
  logic        ovf;

  logic [7:0]  fired4;
  logic        tick4;
  logic        ready4;
  logic        clr4;
  logic        v4;
  logic [2:0]  a4;
  logic [3:0]  ts4;
  logic        ovf4;

  typedef struct packed {
    logic [2:0]  addr;
    logic [15:0] ts;
  } ev_t;

  ev_t sb[$];
  ev_t mon_e;
  int  total = 0;
  int  bad   = 0;

  always #5 clk = ~clk;

  spike_aer_arbiter u_dut (
    .clk            (clk),
    .reset          (rst_n),
    .fired          (fired),
    .timestep_tick  (tick),
    .aer_valid      (aer_valid),
    .aer_ready      (aer_ready),
    .aer_addr       (aer_addr),
    .aer_timestep   (aer_ts),
    .overflow       (ovf),
    .clear_overflow (clr)
  );

  spike_aer_arbiter #(.TS_WIDTH(4)) u_dut4 (
    .clk            (clk),
    .reset          (rst_n),
    .fired          (fired4),
    .timestep_tick  (tick4),
    .aer_valid      (v4),
    .aer_ready      (ready4),
    .aer_addr       (a4),
    .aer_timestep   (ts4),
    .overflow       (ovf4),
    .clear_overflow (clr4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ev(input int a, input int t);
    ev_t e;
    e.addr = 3'(a);
    e.ts   = 16'(t);
    sb.push_back(e);
  endtask

  task automatic do_reset();
    chk("sb_empty_before_reset", sb.size(), 0);
    fired = '0; tick = 1'b0; clr = 1'b0; fired4 = '0; tick4 = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    chk("rst_valid", aer_valid, 0);
    chk("rst_addr", aer_addr, 0);
    chk("rst_ts", aer_ts, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_valid4", v4, 0);
    rst_n = 1'b1;
    step();
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((sb.size() != 0 || aer_valid) && n < 50) begin
      step();
      n++;
    end
    chk({tag, "_sb"}, sb.size(), 0);
    chk({tag, "_idle"}, aer_valid, 0);
  endtask

  // Every accepted beat must match the oldest expected event.
  always @(negedge clk) begin
    if (rst_n && aer_valid && aer_ready) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("ev_addr", aer_addr, mon_e.addr);
        chk("ev_ts", aer_ts, mon_e.ts);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; fired = '0; tick = 1'b0; aer_ready = 1'b1; clr = 1'b0;
    fired4 = '0; tick4 = 1'b0; ready4 = 1'b1; clr4 = 1'b0;
    do_reset();

    // Single spike, 2-cycle latency, one-cycle valid
    push_ev(2, 0);
    fired = 8'b0000_0100; step(); fired = '0;
    chk("t1_not_yet", aer_valid, 0);
    step();
    chk("t1_valid", aer_valid, 1);
    chk("t1_addr", aer_addr, 2);
    chk("t1_ts", aer_ts, 0);
    chk("t1_ovf", ovf, 0);
    step();
    chk("t1_one_cycle", aer_valid, 0);

    // All neurons at once: back-to-back 0..7
    do_reset();
    for (int i = 0; i < 8; i++) push_ev(i, 0);
    fired = 8'hFF; step(); fired = '0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t2_valid", aer_valid, 1);
      chk("t2_addr", aer_addr, i);
    end
    step();
    chk("t2_idle", aer_valid, 0);
    chk("t2_ovf", ovf, 0);

    // Backpressure: held stable for 4 stalled cycles
    do_reset();
    push_ev(5, 0);
    aer_ready = 1'b0;
    fired = 8'b0010_0000; step(); fired = '0;
    step();
    for (int k = 0; k < 4; k++) begin
      chk("t3_hold_valid", aer_valid, 1);
      chk("t3_hold_addr", aer_addr, 5);
      step();
    end
    chk("t3_still_valid", aer_valid, 1);
    aer_ready = 1'b1;
    step();
    chk("t3_accepted", aer_valid, 0);

    // Overflow: slot blocked by neuron 0, neuron 3 fires twice
    do_reset();
    aer_ready = 1'b0;
    push_ev(0, 0);
    push_ev(3, 0);
    fired = 8'h01; step(); fired = '0;
    step();
    chk("t4_blocked_valid", aer_valid, 1);
    fired = 8'h08; step(); fired = '0;
    chk("t4_first_no_ovf", ovf, 0);
    step();
    fired = 8'h08; step(); fired = '0;
    chk("t4_ovf_set", ovf, 1);
    step();
    chk("t4_ovf_held", ovf, 1);
    clr = 1'b1; step(); clr = 1'b0;
    chk("t4_ovf_clr", ovf, 0);
    fired = 8'h08; clr = 1'b1; step(); fired = '0; clr = 1'b0;
    chk("t4_set_dominates", ovf, 1);
    clr = 1'b1; step(); clr = 1'b0;
    chk("t4_ovf_clr2", ovf, 0);
    aer_ready = 1'b1;
    drain("t4_drain");

    // Re-fire in the grant cycle is a new event
    do_reset();
    push_ev(1, 0);
    push_ev(1, 0);
    fired = 8'h02; step();
    step(); fired = '0;
    chk("t5_first_valid", aer_valid, 1);
    chk("t5_first_addr", aer_addr, 1);
    step();
    chk("t5_second_valid", aer_valid, 1);
    chk("t5_second_addr", aer_addr, 1);
    chk("t5_ovf", ovf, 0);
    step();
    chk("t5_idle", aer_valid, 0);

    // Round-robin continues from ptr=2 and wraps
    push_ev(4, 0);
    push_ev(7, 0);
    push_ev(0, 0);
    fired = 8'b1001_0001; step(); fired = '0;
    step(); chk("rr_addr_a", aer_addr, 4);
    step(); chk("rr_addr_b", aer_addr, 7);
    step(); chk("rr_addr_c", aer_addr, 0);
    step(); chk("rr_idle", aer_valid, 0);

    // Timestamp taken before same-cycle increment
    do_reset();
    tick = 1'b1;
    step(); step(); step();
    push_ev(6, 4);
    fired = 8'b0100_0000; step(); fired = '0;
    step(); tick = 1'b0;
    chk("ts_valid", aer_valid, 1);
    chk("ts_addr", aer_addr, 6);
    chk("ts_value", aer_ts, 4);
    step();
    chk("ts_idle", aer_valid, 0);

    // Reset mid-transfer discards slot and pending spikes
    aer_ready = 1'b0;
    fired = 8'h11; step(); fired = '0;
    step();
    chk("mid_pre_valid", aer_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_async_valid", aer_valid, 0);
    chk("mid_async_addr", aer_addr, 0);
    step();
    rst_n = 1'b1; aer_ready = 1'b1;
    step(); step(); step();
    chk("mid_discarded", aer_valid, 0);

    // 4-bit timestep counter wraps after 16 ticks
    do_reset();
    tick4 = 1'b1;
    repeat (17) step();
    tick4 = 1'b0;
    fired4 = 8'h01; step(); fired4 = '0;
    step();
    chk("wrap_valid", v4, 1);
    chk("wrap_addr", a4, 0);
    chk("wrap_ts", ts4, 1);
    step();
    chk("wrap_idle", v4, 0);

    chk("sb_final_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spike_aer_arbiter.md
Name: spike_aer_arbiter

Overview:
- Collects `fired` pulses from an array of NUM_NEURONS LIF neurons.
- Latches each spike as pending, then round-robin arbitrates pending spikes into a single Address-Event Representation (AER) output stream with a valid/ready handshake.
- Each event is stamped with a global timestep counter.
- Sits between the neuron array and the downstream synapse/routing logic. It is the sharing point for the single event bus.

Parameters:
- NUM_NEURONS, 8, number of neuron `fired` inputs (2..64).
- ADDR_WIDTH, 3, AER address width; must equal clog2(NUM_NEURONS).
- TS_WIDTH, 16, width of timestep counter and timestamp field.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- fired  in  NUM_NEURONS  per-neuron spike; bit i high for a cycle = one spike from neuron i.
- timestep_tick  in  1  one-cycle pulse; advances the timestep counter.
- aer_valid  out  1  output event valid.
- aer_ready  in  1  downstream accepts event when high with aer_valid.
- aer_addr  out  ADDR_WIDTH  index of spiking neuron.
- aer_timestep  out  TS_WIDTH  timestep counter value at grant time.
- overflow  out  1  sticky: a spike was dropped.
- clear_overflow  in  1  synchronous clear of overflow.

Behaviour:
- **Reset** (reset=0, async): pending=0, aer_valid=0, aer_addr=0, aer_timestep=0, overflow=0, ts counter=0, rr pointer=0.
- **Pending latch:**
  - Each cycle, pending[i] next = (pending[i] & ~granted[i]) | fired[i].
  - A fire coinciding with that neuron's grant leaves pending[i]=1. This is a new event, not an overflow.
  - fired[i]=1 while pending[i]=1 and not granted this cycle: spike dropped, overflow <= 1.
- **Output slot:**
  - The slot is free when aer_valid=0 or (aer_valid & aer_ready).
  - When free and any pending bit is set: grant one index, load aer_addr/aer_timestep, aer_valid <= 1.
  - When free and none pending: aer_valid <= 0.
  - While aer_valid & ~aer_ready: aer_addr and aer_timestep held stable, no grant.
- **Throughput:** one event per cycle with aer_ready held high.
- **Latency:** fired high at edge E0 sets pending; with a free slot, aer_valid is high after E1, i.e. 2 cycles.
- **Round-robin:**
  - Search starts at index ptr, wrapping NUM_NEURONS-1 -> 0.
  - After a grant of index g, ptr <= g+1 mod NUM_NEURONS.
  - ptr is unchanged when there is no grant.
- **Timestep counter:**
  - Increments on timestep_tick and wraps from 2^TS_WIDTH-1 to 0.
  - aer_timestep captures the counter value before any increment in the same cycle.
- **overflow:**
  - Set dominates clear_overflow when both occur in the same cycle.
  - clear_overflow alone -> 0 next cycle.
- **Reset mid-transfer:** outstanding event and all pending spikes are discarded, with no output glitch beyond the async clear.

Optional Feature:
- Macro: SPIKE_ARB_STARVE_GUARD_EN.
- Defined:
  - A NUM_NEURONS-entry age check forces a grant to any pending bit pending longer than 2*NUM_NEURONS cycles.
  - Lowest index wins among aged bits; ptr still updates to g+1.
- Undefined:
  - Pure round-robin only; no age logic synthesized.

Decomposition:
- Shared package snn_pkg:
  - NUM_NEURONS default, ADDR_WIDTH default, TS_WIDTH.
  - clog2 function.
  - Half-float constants already used by the neuron (e.g. FP16_ONE = 16'h3c00).
- Sub-module rr_arbiter:
  - Combinational round-robin picker: inputs req[NUM_NEURONS] and ptr; outputs grant_valid, grant_idx.
  - Reused later by the synapse scheduler.

Test Plan:
1. Reset, then fired=8'b0000_0100 for one cycle, aer_ready=1 -> aer_valid high 2 cycles later for exactly 1 cycle, aer_addr=2, aer_timestep=0, overflow=0.
2. fired=8'hFF one cycle, aer_ready=1 -> 8 consecutive events with addrs 0,1,...,7, no overflow; then aer_valid=0.
3. Event for addr 5 presented, aer_ready=0 for 4 cycles, then 1 -> aer_addr=5 and aer_valid stable all 4 cycles; accepted on 5th.
4. aer_ready=0, neuron 3 fires twice 2 cycles apart -> overflow=1 and held; pulse clear_overflow -> overflow=0 next cycle.
5. Neuron 1 pending and granted in the same cycle it fires again -> second event for addr 1 emitted, overflow stays 0.
6. TS_WIDTH=4: 17 timestep_tick pulses then fire neuron 0 -> aer_timestep=1 (wrap verified).
